rv_core_state: RTL and testbench

Architectural-state block for the multicycle RV32I processor: parametrised integer register file (x0 hardwired to zero, two combinational read ports with write bypass) plus the program counter and the fetch/execute sequencing FSM. It sits between the instruction-memory interface and the execute datapath. It replaces the flat x0–x31/pc declarations in the processor top, and generalises register width, register count, reset vector and PC step.

---
 rtl/rv_core_pkg.sv | 15 +
 rtl/rv_core_state_if.sv | 51 +++++
 rtl/rv_regfile.sv | 54 +++++
 rtl/rv_core_state.sv | 91 +++++++++
 tb/tb_rv_core_state.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/rv_core_pkg.sv
// Shared types and default constants for the multicycle RV32I core state block.
package rv_core_pkg;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } core_state_e;

  localparam int unsigned XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned PC_STEP_DEFAULT  = 4;
  localparam int unsigned ILEN             = 32;

endpackage

// File: rtl/rv_core_state_if.sv
// Fetch, execute-handshake and register-port bundle of rv_core_state.
// Debug read port exists only when REGFILE_DEBUG_EN is defined.
interface rv_core_state_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic            instr_valid;
  logic [31:0]     instr;
  logic            exec_done;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic            pc_misalign;
  logic [XLEN-1:0] pc;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            rd_we;
  logic [AW-1:0]   rd_addr;
  logic [XLEN-1:0] rd_wdata;
`ifdef REGFILE_DEBUG_EN
  logic [AW-1:0]   dbg_addr;
  logic [XLEN-1:0] dbg_data;
`endif

  // master is the core state block, slave is the surrounding datapath/memory
  modport master (
    output imem_req, imem_addr, instr_valid, instr, pc_misalign, pc, rs1_data, rs2_data,
`ifdef REGFILE_DEBUG_EN
    output dbg_data,
    input  dbg_addr,
`endif
    input  imem_ack, imem_rdata, exec_done, branch_taken, branch_target,
    input  rs1_addr, rs2_addr, rd_we, rd_addr, rd_wdata
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, pc_misalign, pc, rs1_data, rs2_data,
`ifdef REGFILE_DEBUG_EN
    input  dbg_data,
    output dbg_addr,
`endif
    output imem_ack, imem_rdata, exec_done, branch_taken, branch_target,
    output rs1_addr, rs2_addr, rd_we, rd_addr, rd_wdata
  );

endinterface

// File: rtl/rv_regfile.sv
// Integer register file: x0 hardwired to zero, two combinational read ports with write bypass.
// Optional registered debug read port under REGFILE_DEBUG_EN.
module rv_regfile #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  output logic [XLEN-1:0] rs1_data,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs2_data,
`ifdef REGFILE_DEBUG_EN
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data,
`endif
  input  logic            rd_we,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] rd_wdata
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic            wr_en;

  // Reset discards a concurrent write, so the bypass must not show it either.
  assign wr_en = rd_we && (rd_addr != '0) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[rd_addr] <= rd_wdata;
    end
  end

  always_comb begin
    rs1_data = '0;
    if (rs1_addr != '0) rs1_data = (wr_en && rd_addr == rs1_addr) ? rd_wdata : regs_q[rs1_addr];
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_addr != '0) rs2_data = (wr_en && rd_addr == rs2_addr) ? rd_wdata : regs_q[rs2_addr];
  end

`ifdef REGFILE_DEBUG_EN
  always_ff @(posedge clk) begin
    if (rst) dbg_data <= '0;
    else     dbg_data <= (dbg_addr == '0) ? '0 : regs_q[dbg_addr];
  end
`endif

endmodule

// File: rtl/rv_core_state.sv
// Architectural state of the multicycle RV32I core: PC, fetch/execute FSM and register file.
// Optional debug read port is enabled with REGFILE_DEBUG_EN.
module rv_core_state
  import rv_core_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEFAULT,
  parameter int unsigned     NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter int unsigned     PC_STEP  = PC_STEP_DEFAULT
) (
  input logic              clk,
  input logic              rst,
  rv_core_state_if.master  bus
);

  core_state_e     state_q;
  logic [XLEN-1:0] pc_q;
  logic [ILEN-1:0] instr_q;
  logic            imem_req_q;
  logic            instr_valid_q;
  logic            pc_misalign_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_RESET;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      pc_misalign_q <= 1'b0;
    end else begin
      pc_misalign_q <= 1'b0;
      unique case (state_q)
        S_RESET: begin
          state_q    <= S_FETCH;
          imem_req_q <= 1'b1;
        end
        S_FETCH: begin
          if (bus.imem_ack) begin
            instr_q       <= bus.imem_rdata;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b1;
            state_q       <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (bus.exec_done) begin
            if (bus.branch_taken) begin
              // Low target bits are dropped; flag it rather than trap here.
              pc_q          <= {bus.branch_target[XLEN-1:2], 2'b00};
              pc_misalign_q <= |bus.branch_target[1:0];
            end else begin
              pc_q <= pc_q + XLEN'(PC_STEP);
            end
            imem_req_q    <= 1'b1;
            instr_valid_q <= 1'b0;
            state_q       <= S_FETCH;
          end
        end
        default: state_q <= S_RESET;
      endcase
    end
  end

  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.pc          = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.pc_misalign = pc_misalign_q;

  rv_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (bus.rs1_addr),
    .rs1_data (bus.rs1_data),
    .rs2_addr (bus.rs2_addr),
    .rs2_data (bus.rs2_data),
`ifdef REGFILE_DEBUG_EN
    .dbg_addr (bus.dbg_addr),
    .dbg_data (bus.dbg_data),
`endif
    .rd_we    (bus.rd_we),
    .rd_addr  (bus.rd_addr),
    .rd_wdata (bus.rd_wdata)
  );

endmodule

// File: tb/tb_rv_core_state.sv
// Directed bench for rv_core_state: fetch sequencing, branch/misalign, register file,
// PC wrap (second instance) and mid-operation reset.
module tb_rv_core_state;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rv_core_state_if #(.XLEN(32), .AW(5)) bus0 ();
  rv_core_state_if #(.XLEN(32), .AW(5)) bus1 ();

  rv_core_state #(
    .XLEN     (32),
    .NREGS    (32),
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (4)
  ) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.master)
  );

  rv_core_state #(
    .XLEN     (32),
    .NREGS    (32),
    .RESET_PC (32'hFFFF_FFFC),
    .PC_STEP  (4)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.master)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus0.imem_ack = 0; bus0.imem_rdata = '0; bus0.exec_done = 0; bus0.branch_taken = 0;
    bus0.branch_target = '0; bus0.rs1_addr = '0; bus0.rs2_addr = '0; bus0.rd_we = 0;
    bus0.rd_addr = '0; bus0.rd_wdata = '0;
    bus1.imem_ack = 0; bus1.imem_rdata = '0; bus1.exec_done = 0; bus1.branch_taken = 0;
    bus1.branch_target = '0; bus1.rs1_addr = '0; bus1.rs2_addr = '0; bus1.rd_we = 0;
    bus1.rd_addr = '0; bus1.rd_wdata = '0;
`ifdef REGFILE_DEBUG_EN
    bus0.dbg_addr = '0;
    bus1.dbg_addr = '0;
`endif

    tick(); tick();
    check("rst_req", {31'b0, bus0.imem_req}, 32'd0);
    check("rst_valid", {31'b0, bus0.instr_valid}, 32'd0);
    check("rst_misalign", {31'b0, bus0.pc_misalign}, 32'd0);
    check("rst_pc", bus0.pc, 32'h0);
    check("rst_instr", bus0.instr, 32'h0);
    check("rst_pc_dut1", bus1.pc, 32'hFFFF_FFFC);

    // Release reset; req must still be low until the next edge.
    rst = 0;
    #1;
    check("req_low_at_release", {31'b0, bus0.imem_req}, 32'd0);
    tick();
    check("first_req", {31'b0, bus0.imem_req}, 32'd1);
    check("addr0", bus0.imem_addr, 32'h0);
    check("dut1_addr", bus1.imem_addr, 32'hFFFF_FFFC);

    // Fetch 0x0 with immediate ack, then exec_done.
    bus0.imem_ack = 1; bus0.imem_rdata = 32'h0000_0013;
    tick();
    check("exec_valid", {31'b0, bus0.instr_valid}, 32'd1);
    check("instr_latch", bus0.instr, 32'h0000_0013);
    check("req_drop_exec", {31'b0, bus0.imem_req}, 32'd0);
    bus0.imem_ack = 0; bus0.exec_done = 1;
    tick();
    check("addr4", bus0.imem_addr, 32'h4);
    check("req_after_done", {31'b0, bus0.imem_req}, 32'd1);
    bus0.exec_done = 0; bus0.imem_ack = 1; bus0.imem_rdata = 32'h0010_0093;
    tick();
    check("instr2", bus0.instr, 32'h0010_0093);
    bus0.imem_ack = 0; bus0.exec_done = 1;
    tick();
    check("addr8", bus0.imem_addr, 32'h8);
    bus0.exec_done = 0; bus0.imem_ack = 1;
    tick();
    bus0.imem_ack = 0; bus0.exec_done = 1;
    tick();
    check("addrC", bus0.imem_addr, 32'hC);
    bus0.exec_done = 0; bus0.imem_ack = 1;
    tick();
    bus0.imem_ack = 0; bus0.exec_done = 1;
    tick();
    bus0.exec_done = 0; bus0.imem_ack = 1;
    tick();
    check("pc10_exec", bus0.pc, 32'h10);
    check("pc10_valid", {31'b0, bus0.instr_valid}, 32'd1);

    // Taken branch to misaligned target.
    bus0.imem_ack = 0; bus0.exec_done = 1; bus0.branch_taken = 1; bus0.branch_target = 32'h103;
    tick();
    check("branch_addr", bus0.imem_addr, 32'h100);
    check("misalign_pulse", {31'b0, bus0.pc_misalign}, 32'd1);
    // exec_done held in FETCH must be ignored.
    tick();
    check("misalign_clear", {31'b0, bus0.pc_misalign}, 32'd0);
    check("done_ignored_pc", bus0.pc, 32'h100);
    check("req_held", {31'b0, bus0.imem_req}, 32'd1);
    bus0.exec_done = 0; bus0.branch_taken = 0; bus0.branch_target = '0;

    // Register file: bypass, array read, x0 discard.
    bus0.rd_we = 1; bus0.rd_addr = 5'd5; bus0.rd_wdata = 32'hDEAD_BEEF; bus0.rs1_addr = 5'd5;
    #1;
    check("bypass_x5", bus0.rs1_data, 32'hDEAD_BEEF);
    tick();
    bus0.rd_we = 1; bus0.rd_addr = 5'd0; bus0.rd_wdata = 32'hFFFF_FFFF; bus0.rs2_addr = 5'd0;
    #1;
    check("array_x5", bus0.rs1_data, 32'hDEAD_BEEF);
    check("x0_bypass", bus0.rs2_data, 32'h0);
    tick();
    bus0.rd_we = 1; bus0.rd_addr = 5'd3; bus0.rd_wdata = 32'h0000_1234; bus0.rs2_addr = 5'd3;
    #1;
    check("x0_after_write", bus0.rs1_data & 32'h0, 32'h0 & bus0.rs2_data);
    check("bypass_x3", bus0.rs2_data, 32'h0000_1234);
    tick();
    bus0.rd_we = 0;
`ifdef REGFILE_DEBUG_EN
    bus0.dbg_addr = 5'd3;
    tick();
    check("dbg_x3", bus0.dbg_data, 32'h0000_1234);
`endif
    bus0.rs2_addr = 5'd0;
    #1;
    check("x0_read", bus0.rs2_data, 32'h0);

    // PC wrap on the second instance.
    bus1.imem_ack = 1;
    tick();
    bus1.imem_ack = 0; bus1.exec_done = 1;
    tick();
    check("wrap_pc", bus1.pc, 32'h0);
    bus1.exec_done = 0;

    // Reset while fetching with a concurrent write to x7.
    check("pre_rst_req", {31'b0, bus0.imem_req}, 32'd1);
    rst = 1; bus0.rd_we = 1; bus0.rd_addr = 5'd7; bus0.rd_wdata = 32'hAAAA_5555;
    bus0.rs1_addr = 5'd7;
    tick();
    check("rst_mid_req", {31'b0, bus0.imem_req}, 32'd0);
    check("rst_mid_pc", bus0.pc, 32'h0);
    rst = 0; bus0.rd_we = 0;
    #1;
    check("x7_discarded", bus0.rs1_data, 32'h0);
    bus0.rs1_addr = 5'd5;
    #1;
    check("x5_cleared", bus0.rs1_data, 32'h0);
    tick();
    check("req_after_rst", {31'b0, bus0.imem_req}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
